noc_output_arbiter: RTL

Wormhole output-port arbiter for the NoC router. It shares one output link between `N_PORTS` input FIFOs by granting them in round-robin order. Once a port wins, it keeps the link for the whole packet, head flit to tail flit. It pops flits from the winning FIFO only while the downstream buffer has credits. It sits between the per-input `Noc_fifo` instances and the output link register/next-hop FIFO.

---
 rtl/noc_output_arbiter.sv | 118 +++++++++++
 1 files changed

// File: rtl/noc_output_arbiter.sv
// noc_output_arbiter: round-robin wormhole output arbiter with credit flow control.
// Define NOC_ARB_OUT_REG_EN to register o_valid/o_flit (one cycle after o_pop).
module noc_output_arbiter #(
  parameter int N_PORTS = 4,
  parameter int FLIT_WIDTH = 34,
  parameter int CREDITS = 8,
  localparam int CW = $clog2(CREDITS + 1),
  localparam int PW = $clog2(N_PORTS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_clear,
  input  logic [N_PORTS-1:0]            i_req_valid,
  input  logic [N_PORTS*FLIT_WIDTH-1:0] i_req_flit,
  output logic [N_PORTS-1:0]            o_pop,
  output logic                          o_valid,
  output logic [FLIT_WIDTH-1:0]         o_flit,
  input  logic                          i_credit_return,
  output logic [CW-1:0]                 o_credit_count,
  output logic [N_PORTS-1:0]            o_grant,
  output logic                          o_proto_err
);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] owner_q, owner_d, rr_q, rr_d, sel;
  logic [CW-1:0] cred_q, cred_d;
  logic err_q, err_d, sel_vld, send;
  logic [PW:0] idx;
  logic [N_PORTS-1:0] head_v, elig;
  logic [FLIT_WIDTH-1:0] flits [N_PORTS];
  logic [FLIT_WIDTH-1:0] sel_flit;
  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      flits[i] = i_req_flit[i*FLIT_WIDTH +: FLIT_WIDTH];
      head_v[i] = flits[i][FLIT_WIDTH-1];
    end
  end
  assign elig = i_req_valid & head_v;
  // In IDLE pick the first eligible port at or after rr_q; in LOCKED only the owner competes.
  always_comb begin
    sel = owner_q;
    idx = '0;
    if (state_q == IDLE) begin
      sel = rr_q;
      for (int k = N_PORTS-1; k >= 0; k--) begin
        idx = {1'b0, rr_q} + (PW+1)'(k);
        if (idx >= (PW+1)'(N_PORTS)) idx = idx - (PW+1)'(N_PORTS);
        if (elig[idx[PW-1:0]]) sel = idx[PW-1:0];
      end
    end
  end
  assign sel_vld = (state_q == IDLE) ? elig[sel] : i_req_valid[sel];
  assign sel_flit = flits[sel];
  assign send = !i_clear && sel_vld && (cred_q != '0);
  assign o_pop = send ? ({{(N_PORTS-1){1'b0}}, 1'b1} << sel) : '0;
  assign o_grant = (state_q == LOCKED) ? ({{(N_PORTS-1){1'b0}}, 1'b1} << owner_q) : '0;
  assign o_credit_count = cred_q;
  assign o_proto_err = err_q;
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d = rr_q;
    cred_d = cred_q;
    err_d = err_q;
    if (send) begin
      state_d = sel_flit[FLIT_WIDTH-2] ? IDLE : LOCKED;
      owner_d = sel;
      rr_d = (sel == PW'(N_PORTS-1)) ? '0 : sel + 1'b1;
    end
    if (state_q == IDLE && |(i_req_valid & ~head_v)) err_d = 1'b1;
    if (state_q == LOCKED && send && sel_flit[FLIT_WIDTH-1]) err_d = 1'b1;
    if (send && !i_credit_return) cred_d = cred_q - 1'b1;
    else if (!send && i_credit_return) begin
      if (cred_q == CW'(CREDITS)) err_d = 1'b1;
      else cred_d = cred_q + 1'b1;
    end
    if (i_clear) begin
      state_d = IDLE;
      owner_d = '0;
      rr_d = '0;
      cred_d = CW'(CREDITS);
      err_d = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q <= '0;
      cred_q <= CW'(CREDITS);
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q <= rr_d;
      cred_q <= cred_d;
      err_q <= err_d;
    end
  end
`ifdef NOC_ARB_OUT_REG_EN
  logic valid_q;
  logic [FLIT_WIDTH-1:0] flit_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      flit_q <= '0;
    end else begin
      valid_q <= send;
      flit_q <= send ? sel_flit : '0;
    end
  end
  assign o_valid = valid_q;
  assign o_flit = flit_q;
`else
  assign o_valid = send;
  assign o_flit = send ? sel_flit : '0;
`endif
endmodule
